alu_dispatch_ctrl: RTL and testbench
====================================

# alu_dispatch_ctrl

Instruction-side controller that drives `arith_logic_unit`. It accepts one instruction word per transaction over a valid/ready handshake and decodes opcode and register indices. It reads operands from an internal 8-entry register file, issues them to the ALU, captures the registered ALU result and writes it back to the register file. It sits between the fetch stage and the ALU in the 19-bit CPU datapath.

## Interface
- `WORD_SIZE`, 19, datapath and instruction width (from `constants`).
- `OPCODE_SIZE`, package value, opcode field width (from `constants`).
- `NUM_REGS`, 8, register-file depth; index width is `$clog2(NUM_REGS)` = 3.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: instruction word present.
- `instr_ready` out 1: controller can accept.
- `instr` in WORD_SIZE: opcode at `[WORD_SIZE-1 -: OPCODE_SIZE]`, then rd, rs1, rs2 (3 bits each, MSB-first); remaining low bits ignored.
- `alu_op` out OPCODE_SIZE: drives `ALU_control`.
- `alu_a` out WORD_SIZE: drives `reg_data_1`.
- `alu_b` out WORD_SIZE: drives `reg_data_2`.
- `alu_result` in WORD_SIZE: from ALU `result`; registered inside the ALU, valid 1 cycle after issue.
- `host_we` in 1: host register write, used to preload operands.
- `host_waddr` in 3: host write index.
- `host_wdata` in WORD_SIZE: host write data.
- `rd_addr` in 3: debug read index.
- `rd_data` out WORD_SIZE: combinational read of `rd_addr`.
- `done` out 1: one-cycle pulse on writeback.
- `done_data` out WORD_SIZE: written value, held until next `done`.
- `err` out 1: one-cycle pulse on rejected instruction.

## Operation
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: `instr_ready`=1. On `instr_valid&&instr_ready`, latch `instr` and go to READ. Otherwise stay.
  - READ: check the opcode.
    - Legal opcode (ADD, SUB, MUL, DIV, INC, DEC, AND, OR, XOR, NOT): register `alu_op`, `alu_a`=R[rs1], `alu_b`=R[rs2] (0 for INC, DEC, NOT), go to EXEC.
    - Illegal opcode: pulse `err`, return to IDLE, no write.
  - EXEC: hold the ALU inputs one cycle, go to WB.
  - WB: R[rd] <= `alu_result`, `done_data` <= `alu_result`, pulse `done`, return to IDLE.
- `instr_ready`=0 in READ, EXEC and WB. Only one instruction is in flight.
- Register file: no hardwired zero; all entries reset to 0.
- Host write and WB write in the same cycle: the WB write wins and the host write is dropped (even for different indices). Host writes are accepted in every other cycle.
- Operand hazard: the READ sample uses register contents as of that edge. A host write in the same cycle is not forwarded.
- Arithmetic width is owned by the ALU. The controller never extends or truncates; all paths are WORD_SIZE.

## Timing
- Reset values: `instr_ready`=0 while `rst` is high, 1 in the first cycle after release. `alu_op`=0, `alu_a`=0, `alu_b`=0, `done`=0, `done_data`=0, `err`=0, all R=0, state IDLE.
- Latency: accept edge to `done` high = 3 cycles (READ, EXEC, WB). Next accept is possible in the cycle after `done`, so back-to-back throughput is 1 instruction per 4 cycles.
- `err` is asserted 1 cycle after accept.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. The in-flight instruction is discarded with no writeback.
- `instr` is don't-care when `instr_valid`=0. It is sampled only on the accept edge.

## Configuration
- `ALU_DISPATCH_DIV0_CHECK_EN` defined: in READ, a DIV with R[rs2]==0 pulses `err`, does not issue to the ALU and does not write rd; the state returns to IDLE.
- Not defined: a divide by zero is issued normally and whatever the ALU returns is written back.

## Structure
- The opcode enum/localparams (ADD…NOT) live in package `opcodes`; `WORD_SIZE` and `OPCODE_SIZE` live in `constants`.
- Add the FSM state typedef and the instruction field offsets (`RD_MSB`, `RS1_MSB`, `RS2_MSB`) to `constants`.
- One sub-module, `reg_file_8x19`: 2 async read ports (rs1/rs2 and debug), 1 prioritised write port (WB over host), async reset.

## Test plan
- Host writes R1=10 and R2=5, then ADD rd=3, rs1=1, rs2=2 → `done` exactly 3 cycles after accept; `done_data`=15; `rd_data`(3)=15.
- SUB, MUL and DIV on R1=20, R2=4 → 16, 80 and 5. INC and DEC on R1=10 → 11 and 9, with `alu_b`=0 during EXEC.
- AND, OR, XOR on 19'b1010101010101010101 and 19'b1100110011001100110 → 19'b1000100010001000100, 19'b1110111011101110111, 19'b0110011001100110011. NOT of the first operand → 19'b0101010101010101010.
- Unused opcode encoding → `err` pulse 1 cycle after accept, no `done`, all R unchanged.
- Divide by zero (R2=0):
  - with `ALU_DISPATCH_DIV0_CHECK_EN` → `err`, rd unchanged;
  - without it → `done` asserted and rd holds the ALU output.
- Assert `rst` during EXEC → `done` never fires, R reads 0, `instr_ready`=1 the cycle after release. Also: a host write to rd in the WB cycle → rd holds the ALU result.

Source files
------------

// File: rtl/constants.sv
// Shared widths, instruction field layout and controller FSM states for the 19-bit datapath.
package constants;

   localparam int unsigned WORD_SIZE   = 19;
   localparam int unsigned OPCODE_SIZE = 4;
   localparam int unsigned NUM_REGS    = 8;
   localparam int unsigned REG_IDX_W   = $clog2(NUM_REGS);

   // Instruction layout, MSB-first: opcode, rd, rs1, rs2, then ignored bits
   localparam int unsigned RD_MSB  = WORD_SIZE - OPCODE_SIZE - 1;
   localparam int unsigned RS1_MSB = RD_MSB - REG_IDX_W;
   localparam int unsigned RS2_MSB = RS1_MSB - REG_IDX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_e;

   typedef struct packed {
      logic [OPCODE_SIZE-1:0] opcode;
      logic [REG_IDX_W-1:0]   rd;
      logic [REG_IDX_W-1:0]   rs1;
      logic [REG_IDX_W-1:0]   rs2;
   } instr_fields_t;

endpackage

// File: rtl/opcodes.sv
// ALU opcode encodings and decode helpers; encodings above NOT are illegal.
package opcodes;

   import constants::*;

   typedef enum logic [OPCODE_SIZE-1:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      MUL = 4'd2,
      DIV = 4'd3,
      INC = 4'd4,
      DEC = 4'd5,
      AND = 4'd6,
      OR  = 4'd7,
      XOR = 4'd8,
      NOT = 4'd9
   } opcode_e;

   function automatic logic op_legal(input logic [OPCODE_SIZE-1:0] op);
      return op <= OPCODE_SIZE'(NOT);
   endfunction

   // Unary ops get a zero second operand
   function automatic logic op_uses_b(input logic [OPCODE_SIZE-1:0] op);
      return !(op == OPCODE_SIZE'(INC) || op == OPCODE_SIZE'(DEC) || op == OPCODE_SIZE'(NOT));
   endfunction

endpackage

// File: rtl/reg_file_8x19.sv
// 8-entry register file: three async read ports, one write port where writeback beats host.
module reg_file_8x19
   import constants::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] rs1_addr,
   input  logic [REG_IDX_W-1:0] rs2_addr,
   input  logic [REG_IDX_W-1:0] dbg_addr,
   output logic [WORD_SIZE-1:0] rs1_data,
   output logic [WORD_SIZE-1:0] rs2_data,
   output logic [WORD_SIZE-1:0] dbg_data,
   input  logic                 wb_we,
   input  logic [REG_IDX_W-1:0] wb_addr,
   input  logic [WORD_SIZE-1:0] wb_data,
   input  logic                 host_we,
   input  logic [REG_IDX_W-1:0] host_addr,
   input  logic [WORD_SIZE-1:0] host_data
);

   logic [WORD_SIZE-1:0] regs [NUM_REGS];

   assign rs1_data = regs[rs1_addr];
   assign rs2_data = regs[rs2_addr];
   assign dbg_data = regs[dbg_addr];

   // A colliding host write is dropped entirely, even to a different index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '{default: '0};
      end else if (wb_we) begin
         regs[wb_addr] <= wb_data;
      end else if (host_we) begin
         regs[host_addr] <= host_data;
      end
   end

endmodule

// File: rtl/alu_dispatch_ctrl.sv
// Decodes one instruction at a time, issues register operands to the ALU and writes the result back.
// Optional: ALU_DISPATCH_DIV0_CHECK_EN rejects DIV with a zero divisor before issue.
module alu_dispatch_ctrl
   import constants::*;
   import opcodes::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic [WORD_SIZE-1:0]   instr,
   output logic [OPCODE_SIZE-1:0] alu_op,
   output logic [WORD_SIZE-1:0]   alu_a,
   output logic [WORD_SIZE-1:0]   alu_b,
   input  logic [WORD_SIZE-1:0]   alu_result,
   input  logic                   host_we,
   input  logic [REG_IDX_W-1:0]   host_waddr,
   input  logic [WORD_SIZE-1:0]   host_wdata,
   input  logic [REG_IDX_W-1:0]   rd_addr,
   output logic [WORD_SIZE-1:0]   rd_data,
   output logic                   done,
   output logic [WORD_SIZE-1:0]   done_data,
   output logic                   err
);

   state_e                 state;
   state_e                 state_nxt;
   instr_fields_t          instr_q;
   logic [WORD_SIZE-1:0]   rs1_data;
   logic [WORD_SIZE-1:0]   rs2_data;
   logic                   accept_c;
   logic                   reject_c;
   logic                   wb_c;
   logic                   div0_c;
   logic [OPCODE_SIZE-1:0] alu_op_nxt;
   logic [WORD_SIZE-1:0]   alu_a_nxt;
   logic [WORD_SIZE-1:0]   alu_b_nxt;
   logic                   unused_instr_c;

   assign unused_instr_c = ^instr[RS2_MSB-REG_IDX_W:0];

   reg_file_8x19 u_reg_file (
      .clk       (clk),
      .rst       (rst),
      .rs1_addr  (instr_q.rs1),
      .rs2_addr  (instr_q.rs2),
      .dbg_addr  (rd_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .dbg_data  (rd_data),
      .wb_we     (wb_c),
      .wb_addr   (instr_q.rd),
      .wb_data   (alu_result),
      .host_we   (host_we),
      .host_addr (host_waddr),
      .host_data (host_wdata)
   );

`ifdef ALU_DISPATCH_DIV0_CHECK_EN
   assign div0_c = (instr_q.opcode == OPCODE_SIZE'(DIV)) && (rs2_data == '0);
`else
   assign div0_c = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      accept_c   = 1'b0;
      reject_c   = 1'b0;
      wb_c       = 1'b0;
      alu_op_nxt = alu_op;
      alu_a_nxt  = alu_a;
      alu_b_nxt  = alu_b;
      case (state)
         IDLE: begin
            if (instr_valid && instr_ready) begin
               accept_c  = 1'b1;
               state_nxt = READ;
            end
         end
         READ: begin
            if (!op_legal(instr_q.opcode) || div0_c) begin
               reject_c  = 1'b1;
               state_nxt = IDLE;
            end else begin
               alu_op_nxt = instr_q.opcode;
               alu_a_nxt  = rs1_data;
               alu_b_nxt  = op_uses_b(instr_q.opcode) ? rs2_data : '0;
               state_nxt  = EXEC;
            end
         end
         EXEC: state_nxt = WB;
         WB: begin
            wb_c      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs and the latched instruction fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q     <= '0;
         instr_ready <= 1'b0;
         alu_op      <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         done        <= 1'b0;
         done_data   <= '0;
         err         <= 1'b0;
      end else begin
         instr_ready <= (state_nxt == IDLE);
         alu_op      <= alu_op_nxt;
         alu_a       <= alu_a_nxt;
         alu_b       <= alu_b_nxt;
         done        <= wb_c;
         err         <= reject_c;
         if (accept_c) begin
            instr_q.opcode <= instr[WORD_SIZE-1 -: OPCODE_SIZE];
            instr_q.rd     <= instr[RD_MSB -: REG_IDX_W];
            instr_q.rs1    <= instr[RS1_MSB -: REG_IDX_W];
            instr_q.rs2    <= instr[RS2_MSB -: REG_IDX_W];
         end
         if (wb_c) begin
            done_data <= alu_result;
         end
      end
   end

endmodule

// File: tb/tb_alu_dispatch_ctrl.sv
// Bench for alu_dispatch_ctrl: directed table, multi-cycle corner sequences and random traffic
// against a register-array model, with a registered ALU stand-in.
module tb_alu_dispatch_ctrl;
   import constants::*;
   import opcodes::*;

`ifdef ALU_DISPATCH_DIV0_CHECK_EN
   localparam bit DIV0_EN = 1'b1;
`else
   localparam bit DIV0_EN = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   instr_valid = 1'b0;
   logic                   instr_ready;
   logic [WORD_SIZE-1:0]   instr = '0;
   logic [OPCODE_SIZE-1:0] alu_op;
   logic [WORD_SIZE-1:0]   alu_a;
   logic [WORD_SIZE-1:0]   alu_b;
   logic [WORD_SIZE-1:0]   alu_result = '0;
   logic                   host_we = 1'b0;
   logic [2:0]             host_waddr = '0;
   logic [WORD_SIZE-1:0]   host_wdata = '0;
   logic [2:0]             rd_addr = '0;
   logic [WORD_SIZE-1:0]   rd_data;
   logic                   done;
   logic [WORD_SIZE-1:0]   done_data;
   logic                   err;

   int n_vec = 0;
   int n_mis = 0;
   logic [WORD_SIZE-1:0] m_r [8];

   typedef struct {
      logic [3:0]  op;
      int          rd;
      int          rs1;
      int          rs2;
      logic [18:0] a;
      logic [18:0] b;
      logic [18:0] exp;
      bit          exp_err;
      string       name;
   } vec_t;

   alu_dispatch_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .host_we     (host_we),
      .host_waddr  (host_waddr),
      .host_wdata  (host_wdata),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .done        (done),
      .done_data   (done_data),
      .err         (err)
   );

   always #10 clk = ~clk;

   function automatic logic [18:0] ref_alu(input logic [3:0] op, input logic [18:0] a, input logic [18:0] b);
      longint unsigned x, y, r;
      x = longint'(a);
      y = longint'(b);
      case (op)
         ADD:     r = x + y;
         SUB:     r = x - y;
         MUL:     r = x * y;
         DIV:     r = (y == 0) ? 64'h7FFFF : x / y;
         INC:     r = x + 1;
         DEC:     r = x - 1;
         AND:     r = x & y;
         OR:      r = x | y;
         XOR:     r = x ^ y;
         NOT:     r = ~x;
         default: r = 0;
      endcase
      return 19'(r);
   endfunction

   // Registered ALU stand-in: result follows the issued operands by one cycle
   always @(posedge clk) alu_result <= ref_alu(alu_op, alu_a, alu_b);

   function automatic vec_t mk(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                               input logic [18:0] a, input logic [18:0] b, input logic [18:0] exp,
                               input bit exp_err, input string name);
      vec_t v;
      v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.a = a; v.b = b; v.exp = exp; v.exp_err = exp_err; v.name = name;
      return v;
   endfunction

   task automatic check(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, what, act, exp);
      end
   endtask

   task automatic check_regs(input string nm);
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i);
         #1;
         check(nm, $sformatf("R%0d", i), 32'(rd_data), 32'(m_r[i]));
      end
   endtask

   task automatic host_wr(input int idx, input logic [18:0] v);
      host_we    = 1'b1;
      host_waddr = 3'(idx);
      host_wdata = v;
      @(posedge clk); #1;
      host_we    = 1'b0;
      m_r[idx]   = v;
   endtask

   // hk: cycle after accept (0 = READ, 2 = WB) in which a host write is driven; -1 for none
   task automatic issue(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                        input bit exp_err, input logic [18:0] exp_val,
                        input int hk, input int h_idx, input logic [18:0] h_val, input string nm);
      int n, done_cyc, err_cyc, done_cnt, err_cnt;
      logic [18:0] a_old, b_old;
      bit unary;
      unary = (op == INC) || (op == DEC) || (op == NOT);
      a_old = m_r[rs1];
      b_old = unary ? 19'd0 : m_r[rs2];
      n = 0;
      while (!instr_ready && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check(nm, "ready", 32'(instr_ready), 32'd1);
      instr = {op, 3'(rd), 3'(rs1), 3'(rs2), 6'($urandom)};
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = 19'($urandom);
      done_cyc = -1; err_cyc = -1; done_cnt = 0; err_cnt = 0;
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (hk == k) begin
            host_we = 1'b1; host_waddr = 3'(h_idx); host_wdata = h_val;
         end else begin
            host_we = 1'b0;
         end
         if (k == 0) check(nm, "busy_ready", 32'(instr_ready), 32'd0);
         if (k == 1 && !exp_err) begin
            check(nm, "alu_op", 32'(alu_op), 32'(op));
            check(nm, "alu_a", 32'(alu_a), 32'(a_old));
            check(nm, "alu_b", 32'(alu_b), 32'(b_old));
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (err) begin
            err_cnt++;
            if (err_cyc < 0) err_cyc = k;
         end
      end
      host_we = 1'b0;
      check(nm, "done_cycle", 32'(done_cyc), exp_err ? 32'hFFFF_FFFF : 32'd3);
      check(nm, "err_cycle", 32'(err_cyc), exp_err ? 32'd1 : 32'hFFFF_FFFF);
      check(nm, "done_count", 32'(done_cnt), exp_err ? 32'd0 : 32'd1);
      check(nm, "err_count", 32'(err_cnt), exp_err ? 32'd1 : 32'd0);
      if (!exp_err) check(nm, "done_data", 32'(done_data), 32'(exp_val));
      if (hk == 0) m_r[h_idx] = h_val;
      if (hk == 2 && exp_err) m_r[h_idx] = h_val;
      if (!exp_err) m_r[rd] = exp_val;
      check_regs(nm);
   endtask

   localparam logic [18:0] P1 = 19'b1010101010101010101;
   localparam logic [18:0] P2 = 19'b1100110011001100110;

   initial begin
      vec_t tbl [$];
      logic [3:0] op;
      int rd, rs1, rs2, hk, hi;
      bit e;
      logic [18:0] v;

      for (int i = 0; i < 8; i++) m_r[i] = '0;

      tbl.push_back(mk(ADD, 3, 1, 2, 19'd10, 19'd5, 19'd15, 1'b0, "add"));
      tbl.push_back(mk(SUB, 4, 1, 2, 19'd20, 19'd4, 19'd16, 1'b0, "sub"));
      tbl.push_back(mk(MUL, 5, 1, 2, 19'd20, 19'd4, 19'd80, 1'b0, "mul"));
      tbl.push_back(mk(DIV, 6, 1, 2, 19'd20, 19'd4, 19'd5, 1'b0, "div"));
      tbl.push_back(mk(INC, 7, 1, 2, 19'd10, 19'd4, 19'd11, 1'b0, "inc"));
      tbl.push_back(mk(DEC, 0, 1, 2, 19'd10, 19'd4, 19'd9, 1'b0, "dec"));
      tbl.push_back(mk(AND, 3, 1, 2, P1, P2, 19'b1000100010001000100, 1'b0, "and"));
      tbl.push_back(mk(OR,  4, 1, 2, P1, P2, 19'b1110111011101110111, 1'b0, "or"));
      tbl.push_back(mk(XOR, 5, 1, 2, P1, P2, 19'b0110011001100110011, 1'b0, "xor"));
      tbl.push_back(mk(NOT, 6, 1, 2, P1, P2, 19'b0101010101010101010, 1'b0, "not"));
      tbl.push_back(mk(4'd12, 7, 1, 2, 19'd3, 19'd4, 19'd0, 1'b1, "illegal"));
      tbl.push_back(mk(DIV, 6, 1, 2, 19'd20, 19'd0, 19'h7FFFF, DIV0_EN, "div0"));

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("reset", "ready", 32'(instr_ready), 32'd0);
      check("reset", "alu_op", 32'(alu_op), 32'd0);
      check("reset", "alu_a", 32'(alu_a), 32'd0);
      check("reset", "alu_b", 32'(alu_b), 32'd0);
      check("reset", "done", 32'(done), 32'd0);
      check("reset", "done_data", 32'(done_data), 32'd0);
      check("reset", "err", 32'(err), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset", "ready_after", 32'(instr_ready), 32'd1);
      check_regs("reset");

      foreach (tbl[i]) begin
         host_wr(tbl[i].rs1, tbl[i].a);
         host_wr(tbl[i].rs2, tbl[i].b);
         issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].exp_err, tbl[i].exp,
               -1, 0, 19'd0, tbl[i].name);
      end

      // Host write to rs1 during READ is not forwarded into the operand
      host_wr(1, 19'd10);
      host_wr(2, 19'd5);
      issue(ADD, 3, 1, 2, 1'b0, 19'd15, 0, 1, 19'd100, "hazard");
      // Host write in the WB cycle loses, to rd or to any other index
      issue(SUB, 3, 1, 2, 1'b0, 19'd95, 2, 3, 19'd777, "wb_collide_rd");
      issue(ADD, 4, 1, 2, 1'b0, 19'd105, 2, 0, 19'd123, "wb_collide_other");

      // Reset during EXEC discards the instruction
      instr = {ADD, 3'd5, 3'd1, 3'd2, 6'd0};
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      check("mid_reset", "ready", 32'(instr_ready), 32'd0);
      check("mid_reset", "alu_a", 32'(alu_a), 32'd0);
      check("mid_reset", "alu_b", 32'(alu_b), 32'd0);
      check("mid_reset", "done_data", 32'(done_data), 32'd0);
      check_regs("mid_reset");
      repeat (2) begin
         @(posedge clk); #1;
         check("mid_reset", "done_in_reset", 32'(done), 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_reset", "ready_after", 32'(instr_ready), 32'd1);
      repeat (3) begin
         check("mid_reset", "done_after", 32'(done), 32'd0);
         @(posedge clk); #1;
      end
      check_regs("mid_reset_after");

      // Random traffic against the register-array model
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(1, 2)) begin
            v = ($urandom_range(0, 3) == 0) ? 19'($urandom_range(0, 3)) : 19'($urandom);
            host_wr($urandom_range(0, 7), v);
         end
         case ($urandom_range(0, 11))
            10:      op = 4'd13;
            11:      op = 4'd15;
            default: op = 4'($urandom_range(0, 9));
         endcase
         rd  = $urandom_range(0, 7);
         rs1 = $urandom_range(0, 7);
         rs2 = $urandom_range(0, 7);
         e   = (op > 4'd9) || (DIV0_EN && op == DIV && m_r[rs2] == 19'd0);
         case ($urandom_range(0, 5))
            0:       hk = 0;
            1:       hk = 2;
            default: hk = -1;
         endcase
         hi = $urandom_range(0, 7);
         issue(op, rd, rs1, rs2, e, ref_alu(op, m_r[rs1], m_r[rs2]), hk, hi, 19'($urandom),
               $sformatf("rand%0d", it));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
